matrix_receiver: RTL

Receive-side counterpart of the matrix UART display path. The block consumes ASCII bytes from the UART receiver and parses whitespace-separated decimal numbers (0–511). It writes them row-major, compactly, into 25 element slots: element k goes to slot k, with no 5-column stride. It sits between the UART RX and matrix storage, and the top level starts it once per matrix entry with the intended dimensions.

---
 rtl/matrix_receiver_if.sv | 21 ++
 rtl/matrix_receiver.sv | 83 ++++++++
 2 files changed

// File: rtl/matrix_receiver_if.sv
// matrix_receiver_if: control, UART byte stream and parsed-matrix bundle for matrix_receiver
interface matrix_receiver_if;
    logic         start;
    logic [2:0]   matrix_row;
    logic [2:0]   matrix_col;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         busy;
    logic         done;
    logic         error;
    logic [4:0]   elem_cnt;
    logic [224:0] data_flat;
    modport master (
        output start, matrix_row, matrix_col, rx_valid, rx_data,
        input  busy, done, error, elem_cnt, data_flat
    );
    modport slave (
        input  start, matrix_row, matrix_col, rx_valid, rx_data,
        output busy, done, error, elem_cnt, data_flat
    );
endinterface

// File: rtl/matrix_receiver.sv
// matrix_receiver: parses whitespace-separated decimal numbers from UART bytes
// into up to 25 compact 9-bit slots, row-major.
module matrix_receiver #(
    parameter int MAX_VAL = 511
) (
    input logic              clk,
    input logic              rst,
    matrix_receiver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SKIP, NUM, DONE, ERR, WAIT_RELEASE} state_t;
    state_t      state;
    logic [4:0]  expected;
    logic [12:0] acc;
    logic        is_digit, is_sep, bad_dims;
    logic [3:0]  digit;
    logic [12:0] next_acc;
    assign is_digit = bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39;
    assign is_sep   = bus.rx_data == 8'h20 || bus.rx_data == 8'h0a || bus.rx_data == 8'h0d;
    assign digit    = bus.rx_data[3:0];
    assign next_acc = acc * 13'd10 + 13'(digit);
    assign bad_dims = bus.matrix_row == 3'd0 || bus.matrix_row > 3'd5 ||
                      bus.matrix_col == 3'd0 || bus.matrix_col > 3'd5;
    // Failure and completion are flagged on the deciding edge so the
    // DONE/ERR cycle already shows done/error with busy low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            expected      <= '0;
            acc           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.elem_cnt  <= '0;
            bus.data_flat <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    expected      <= 5'(bus.matrix_row) * 5'(bus.matrix_col);
                    acc           <= '0;
                    bus.elem_cnt  <= '0;
                    bus.data_flat <= '0;
                    bus.error     <= bad_dims;
                    bus.busy      <= !bad_dims;
                    state         <= bad_dims ? ERR : SKIP;
                end
                SKIP: if (bus.rx_valid) begin
                    if (is_digit) begin
                        acc   <= 13'(digit);
                        state <= NUM;
                    end else if (!is_sep) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= ERR;
                    end
                end
                NUM: if (bus.rx_valid) begin
                    if (is_digit && next_acc <= 13'(MAX_VAL)) begin
                        acc <= next_acc;
                    end else if (is_sep) begin
                        bus.data_flat[9*bus.elem_cnt +: 9] <= acc[8:0];
                        bus.elem_cnt <= bus.elem_cnt + 5'd1;
                        if (bus.elem_cnt + 5'd1 == expected) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= DONE;
                        end else begin
                            state <= SKIP;
                        end
                    end else begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= ERR;
                    end
                end
                DONE:         state <= WAIT_RELEASE;
                ERR:          state <= WAIT_RELEASE;
                WAIT_RELEASE: if (!bus.start) state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end
endmodule
